// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture/averaging engine: IAGC status
// encoding, FSM state encoding and width helpers.
package adc_capture_pkg;

  localparam logic [3:0] IAGC_RESET     = 4'b0000;
  localparam logic [3:0] IAGC_INIT      = 4'b0001;
  localparam logic [3:0] IAGC_IDLE      = 4'b0010;
  localparam logic [3:0] IAGC_SAMPLE    = 4'b0011;
  localparam logic [3:0] IAGC_CMD_PARSE = 4'b0100;
  localparam logic [3:0] IAGC_CMD_READ  = 4'b0101;
  localparam logic [3:0] IAGC_CMD_ERROR = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READ    = 2'd2
  } state_e;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Wide enough to sum 2^AVG_LOG2_MAX full-scale samples without overflow.
  function automatic int acc_width(input int data_size, input int avg_log2_max);
    return data_size + avg_log2_max;
  endfunction

endpackage

// File: rtl/adc_capture_avg_if.sv
// Sample-in and frame-out stream signals of the capture engine.
// The slave modport is the engine's view, master is the producer/consumer side.
interface adc_capture_avg_if #(
  parameter int DATA_SIZE    = 16,
  parameter int NUM_CHANNELS = 2
);
  logic                              i_sample_valid;
  logic [NUM_CHANNELS*DATA_SIZE-1:0] i_samples;
  logic                              i_rd_ready;
  logic                              o_rd_valid;
  logic [NUM_CHANNELS*DATA_SIZE-1:0] o_rd_data;

  modport slave (
    input  i_sample_valid, i_samples, i_rd_ready,
    output o_rd_valid, o_rd_data
  );

  modport master (
    output i_sample_valid, i_samples, i_rd_ready,
    input  o_rd_valid, o_rd_data
  );
endinterface

// File: rtl/adc_capture_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module adc_capture_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: no reset on the array or read register; a reset would stop the
  // tools mapping this onto block RAM, and nothing reads a slot before it is written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/adc_capture_avg.sv
// Capture engine: averages each channel over 2^k valid frames, buffers up to
// DEPTH averaged frames, then streams them out at one frame per two cycles.
module adc_capture_avg
  import adc_capture_pkg::*;
#(
  parameter int DATA_SIZE        = 16,
  parameter int NUM_CHANNELS     = 2,
  parameter int DEPTH            = 256,
  parameter int AVG_LOG2_MAX     = 4,
  parameter int IAGC_STATUS_SIZE = 4
) (
  input  logic                              i_sys_clock,
  input  logic                              i_reset,
  input  logic [IAGC_STATUS_SIZE-1:0]       i_iagc_status,
  input  logic                              i_init_done,
  input  logic [$clog2(AVG_LOG2_MAX+1)-1:0] i_avg_log2,
  input  logic [$clog2(DEPTH):0]            i_capture_len,
  adc_capture_avg_if.slave                  bus,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [$clog2(DEPTH):0]            o_frame_count,
  output logic                              o_dropped
);
  localparam int AW    = addr_width(DEPTH);
  localparam int CW    = AW + 1;
  localparam int KW    = $clog2(AVG_LOG2_MAX + 1);
  localparam int SW    = AVG_LOG2_MAX + 1;
  localparam int ACC_W = acc_width(DATA_SIZE, AVG_LOG2_MAX);
  localparam int FW    = NUM_CHANNELS * DATA_SIZE;

  localparam logic [IAGC_STATUS_SIZE-1:0] STATUS_RESET  = IAGC_STATUS_SIZE'(IAGC_RESET);
  localparam logic [IAGC_STATUS_SIZE-1:0] STATUS_SAMPLE = IAGC_STATUS_SIZE'(IAGC_SAMPLE);

  state_e                        state_q, state_d;
  logic [IAGC_STATUS_SIZE-1:0]   status_prev_q;
  logic [KW-1:0]                 k_q, k_d;
  logic [CW-1:0]                 len_q, len_d;
  logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 frame_count_q, frame_count_d;
  logic                          dropped_q, dropped_d;
  logic [SW-1:0]                 sub_cnt_q, sub_cnt_d;
  logic signed [ACC_W-1:0]       acc_q [NUM_CHANNELS];
  logic signed [ACC_W-1:0]       acc_d [NUM_CHANNELS];
  logic                          rd_fill_q, rd_fill_d;
  logic                          rd_valid_q, rd_valid_d;
  logic [FW-1:0]                 rd_data_q, rd_data_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic signed [ACC_W-1:0]       acc_sum [NUM_CHANNELS];
  logic [FW-1:0]                 avg_frame;
  logic [SW-1:0]                 block_last;
  logic                          abort, start;
  logic                          ram_we, ram_re;
  logic [AW-1:0]                 ram_raddr;
  logic [FW-1:0]                 ram_rdata;

  // Running sums including the current sample, and the floored average of them.
  always_comb begin
    avg_frame = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      acc_sum[c] = acc_q[c] + ACC_W'($signed(bus.i_samples[c*DATA_SIZE +: DATA_SIZE]));
      avg_frame[c*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(acc_sum[c] >>> k_q);
    end
  end

  assign block_last = (SW'(1) << k_q) - SW'(1);
  assign abort      = (i_iagc_status == STATUS_RESET);
  assign start      = (status_prev_q != STATUS_SAMPLE) && (i_iagc_status == STATUS_SAMPLE)
                      && i_init_done;
  assign ram_re     = (state_q == ST_READ);
  // While a frame is presented, prefetch the next one so it is ready after the bubble.
  assign ram_raddr  = rd_valid_q ? rd_ptr_q + AW'(1) : rd_ptr_q;

  // NOTE: every _d gets its hold value first, so no path through the case
  // statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    len_d         = len_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    frame_count_d = frame_count_q;
    dropped_d     = dropped_q;
    sub_cnt_d     = sub_cnt_q;
    acc_d         = acc_q;
    rd_fill_d     = rd_fill_q;
    rd_valid_d    = rd_valid_q;
    rd_data_d     = rd_data_q;
    ram_we        = 1'b0;

    if (abort) begin
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      sub_cnt_d  = '0;
      acc_d      = '{default: '0};
      rd_fill_d  = 1'b0;
      rd_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d       = ST_CAPTURE;
            k_d           = (i_avg_log2 > KW'(AVG_LOG2_MAX)) ? KW'(AVG_LOG2_MAX) : i_avg_log2;
            len_d         = (i_capture_len == '0 || i_capture_len > CW'(DEPTH))
                            ? CW'(DEPTH) : i_capture_len;
            frame_count_d = '0;
            dropped_d     = 1'b0;
            wr_ptr_d      = '0;
            sub_cnt_d     = '0;
            acc_d         = '{default: '0};
          end
        end
        ST_CAPTURE: begin
          if (bus.i_sample_valid) begin
            if (sub_cnt_q == block_last) begin
              ram_we        = 1'b1;
              wr_ptr_d      = wr_ptr_q + AW'(1);
              frame_count_d = frame_count_q + CW'(1);
              sub_cnt_d     = '0;
              acc_d         = '{default: '0};
              if (frame_count_q + CW'(1) == len_q) begin
                state_d    = ST_READ;
                rd_ptr_d   = '0;
                rd_fill_d  = 1'b0;
                rd_valid_d = 1'b0;
              end
            end else begin
              sub_cnt_d = sub_cnt_q + SW'(1);
              acc_d     = acc_sum;
            end
          end
        end
        ST_READ: begin
          if (bus.i_sample_valid) dropped_d = 1'b1;
          if (rd_valid_q) begin
            if (bus.i_rd_ready) begin
              rd_valid_d = 1'b0;
              rd_fill_d  = 1'b1;
              rd_ptr_d   = rd_ptr_q + AW'(1);
              if ({1'b0, rd_ptr_q} == len_q - CW'(1)) state_d = ST_IDLE;
            end
          end else if (rd_fill_q) begin
            rd_data_d  = ram_rdata;
            rd_valid_d = 1'b1;
            rd_fill_d  = 1'b0;
          end else begin
            rd_fill_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_READ);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge i_sys_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      status_prev_q <= '0;
      k_q           <= '0;
      len_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_count_q <= '0;
      dropped_q     <= 1'b0;
      sub_cnt_q     <= '0;
      acc_q         <= '{default: '0};
      rd_fill_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      status_prev_q <= i_iagc_status;
      k_q           <= k_d;
      len_q         <= len_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_count_q <= frame_count_d;
      dropped_q     <= dropped_d;
      sub_cnt_q     <= sub_cnt_d;
      acc_q         <= acc_d;
      rd_fill_q     <= rd_fill_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  adc_capture_ram #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (i_sys_clock),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (avg_frame),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_data  = rd_data_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_frame_count  = frame_count_q;
  assign o_dropped      = dropped_q;
endmodule
